// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory (incl. switch/LED window).
// Each access runs IDLE -> ISSUE -> [WAIT x RD_LAT] -> RESP with fully registered outputs.
module dmem_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 64,
    parameter int RD_LAT = 1    // legal 1..7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        grant,
    output logic              busy
);

    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [1:0]        win;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              last_m1;   // 1 when m1 was served last
    logic [CNT_W-1:0]  cnt;

    // Round-robin pick: on a tie the requester not served last wins.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        win = 2'b00;
        if (m0_req && m1_req)
            win = last_m1 ? 2'b01 : 2'b10;
        else if (m0_req)
            win = 2'b01;
        else if (m1_req)
            win = 2'b10;
        win_we    = win[1] ? m1_we    : m0_we;
        win_addr  = win[1] ? m1_addr  : m0_addr;
        win_wdata = win[1] ? m1_wdata : m0_wdata;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (win != 2'b00) state_nxt = ISSUE;
            ISSUE:   state_nxt = mem_wr ? RESP : WAIT;
            WAIT:    if (cnt == CNT_W'(1)) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: every output register, including the rdata holding registers, is
    // reset so an aborted transaction leaves nothing visible behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wr    <= 1'b0;
            mem_rd    <= 1'b0;
            grant     <= 2'b00;
            busy      <= 1'b0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            last_m1   <= 1'b1;
            cnt       <= '0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (win != 2'b00) begin
                        grant     <= win;
                        busy      <= 1'b1;
                        mem_addr  <= win_addr;
                        mem_wdata <= win_wdata;
                        mem_wr    <= win_we;
                        mem_rd    <= ~win_we;
                        cnt       <= CNT_W'(RD_LAT);
                    end
                end
                ISSUE: begin
                    // A write completes straight away; a read keeps its strobe into WAIT.
                    mem_wr <= 1'b0;
                    if (mem_wr) begin
                        m0_ack <= grant[0];
                        m1_ack <= grant[1];
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        mem_rd <= 1'b0;
                        m0_ack <= grant[0];
                        m1_ack <= grant[1];
                        if (grant[0])
                            m0_rdata <= mem_rdata;
                        else
                            m1_rdata <= mem_rdata;
                    end
                end
                RESP: begin
                    grant   <= 2'b00;
                    busy    <= 1'b0;
                    last_m1 <= grant[1];
                end
                default: begin
                    grant  <= 2'b00;
                    busy   <= 1'b0;
                    mem_wr <= 1'b0;
                    mem_rd <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates single-port access to the 64-bit data memory (incl. its switch/LED I/O window) between two requesters: m0 = CPU load/store unit, m1 = program loader/debug port.
- Sequences each access as a registered multi-cycle transaction: request, strobe, read-wait, one-cycle acknowledge.
- Sits between the core datapath and the data memory; the memory's address, write/read strobes and data buses are driven only by this block.

Parameters:
- ADDR_W, 13, memory address width
- DATA_W, 64, memory data width
- RD_LAT, 1, cycles from read strobe to valid memory read data; legal 1..7

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- m0_req  in  1  m0 request; held high until m0_ack
- m0_we  in  1  m0 write (1) / read (0)
- m0_addr  in  ADDR_W  m0 address
- m0_wdata  in  DATA_W  m0 write data
- m0_ack  out  1  one-cycle completion pulse to m0
- m0_rdata  out  DATA_W  m0 read data, valid while m0_ack=1 and held afterwards
- m1_req / m1_we / m1_addr / m1_wdata / m1_ack / m1_rdata  same as m0, for requester m1
- mem_addr  out  ADDR_W  to memory address input
- mem_wr  out  1  memory write strobe
- mem_rd  out  1  memory read strobe
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- grant  out  2  one-hot owner of the current transaction; 00 when IDLE
- busy  out  1  1 in any state other than IDLE

Behaviour:
- All outputs are registered. The one-clock / async active-low reset is fixed.
- Reset (async, takes effect immediately, including mid-transaction): state=IDLE; mem_wr=mem_rd=0; mem_addr=0; mem_wdata=0; grant=00; busy=0; both acks 0; both rdata 0; round-robin pointer favours m0. An aborted transaction is never acknowledged.
- FSM: IDLE -> ISSUE -> (write: RESP | read: WAIT) -> RESP -> IDLE.
- IDLE: sample reqs; if none, stay.
  - If only one req is set, grant that requester.
  - If both are set, grant the requester not served last (round-robin); then latch we/addr/wdata of the winner and go to ISSUE.
- ISSUE (1 cycle): mem_addr and mem_wdata = latched values; mem_wr=we, mem_rd=~we.
  - Write -> RESP.
  - Read -> WAIT with counter = RD_LAT.
- WAIT (RD_LAT cycles): mem_rd stays 1 and mem_addr is stable; counter decrements.
  - On the last WAIT cycle, capture mem_rdata into the winner's rdata register, then go to RESP.
- RESP (1 cycle): mem_wr=mem_rd=0; winner's ack=1; update the round-robin pointer to the winner; -> IDLE.
- mem_addr is held from ISSUE through RESP. grant is valid ISSUE..RESP. busy=1 in ISSUE, WAIT and RESP.
- Latency, with req sampled in IDLE at cycle 0:
  - Write: strobe in cycle 1, ack in cycle 2.
  - Read: strobe in cycles 1..1+RD_LAT, ack in cycle 2+RD_LAT.
- Back-to-back: a mandatory IDLE cycle follows RESP. A req still high in that IDLE cycle is treated as a new request, so requesters drop req in the cycle after ack.
- Requester input changes after a grant are ignored, because the inputs are latched.
- The non-winner's rdata and ack are untouched.
- The I/O window (e.g. address 0x100, switches/LEDs) is not decoded here; it is passed through like any other address.
- Never assert mem_wr and mem_rd together. Never assert both acks in one cycle.

Test Plan:
- Reset, then m0 writes addr 0x000, data 8 -> mem_wr=1 with mem_addr=0, mem_wdata=8 in cycle 1 only; m0_ack in cycle 2; grant=01 during cycles 1-2.
- m0 reads 0x000 with RD_LAT=1, memory returns 8 -> mem_rd high in cycles 1-2; m0_ack in cycle 3 with m0_rdata=8, which then holds after the ack.
- m1 reads I/O address 0x100 with mem_rdata = sw value 9 -> m1_ack with m1_rdata=9; m0_rdata unchanged.
- m0 and m1 request simultaneously and repeatedly after reset -> grants in order m0, m1, m0, m1; one idle cycle between transactions; acks never overlap.
- rst_n pulled low during WAIT of a read -> mem_rd=0 and busy=0 immediately; no ack is ever issued; after release, a fresh m0 request completes normally.
- RD_LAT=3 build: read -> mem_rd high for 4 cycles; ack at cycle 5 with the correct data; mem_wr and mem_rd are never high together.
